// File: rtl/pov_pkg.sv
// rtl/pov_pkg.sv - shared types and constants for the POV string receiver
// Contents: receiver state enum, NULL_CHAR terminator value, DATA_BITS per frame.
package pov_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_STORE
  } rx_state_t;

  localparam logic [7:0] NULL_CHAR = 8'h00;
  localparam int         DATA_BITS = 8;

endpackage

// File: rtl/pov_string_buffer.sv
// rtl/pov_string_buffer.sv - DEPTH x 8 string storage, sync write / comb read
// Ports:
//   clk      in   write clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  contents at i_raddr (combinational)
module pov_string_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  // Contents are intentionally not reset.
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pov_string_receiver.sv
// rtl/pov_string_receiver.sv - UART receive controller filling a null-terminated string buffer
// Optional feature macro: POV_RX_PARITY_EN (adds an even-parity bit after the data bits).
// Ports:
//   clk         in   system clock
//   Reset       in   asynchronous active-low reset
//   RxD         in   asynchronous serial line, idles high
//   Ack         in   transmitter has consumed the string; clears Complete
//   RdAddr      in   buffer read address
//   RdData      out  buffer contents at RdAddr (combinational)
//   Complete    out  null-terminated string ready (level)
//   Length      out  characters before the terminator
//   FrameError  out  one-cycle pulse on bad stop (or parity) bit
//   Overflow    out  one-cycle pulse on buffer full or character dropped
module pov_string_receiver
  import pov_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 32,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          RxD,
  input  logic          Ack,
  input  logic [AW-1:0] RdAddr,
  output logic [7:0]    RdData,
  output logic          Complete,
  output logic [AW-1:0] Length,
  output logic          FrameError,
  output logic          Overflow
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [AW-1:0]        r_wptr;
  logic                 r_complete;
  logic [AW-1:0]        r_length;
  logic                 r_frame_err;
  logic                 r_overflow;

  logic                 w_is_null;
  logic                 w_at_last;
  logic                 w_we;
  logic [7:0]           w_wdata;

  assign w_is_null = (r_shift == NULL_CHAR);
  assign w_at_last = (r_wptr == PTR_LAST);
  // Writes are blocked while a finished string awaits Ack.
  assign w_we      = (r_state == ST_STORE) && !r_complete;
  // The last slot always receives the terminator so the string stays null-terminated.
  assign w_wdata   = w_at_last ? NULL_CHAR : r_shift;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_wptr      <= '0;
      r_complete  <= 1'b0;
      r_length    <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_rx_meta   <= RxD;
      r_rx_sync   <= r_rx_meta;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      // A Store that sets Complete below overrides this clear.
      if (Ack) r_complete <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!r_rx_sync) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef POV_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef POV_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            // Even parity: data bits plus parity bit must have an even count of ones.
            if (^{r_shift, r_rx_sync}) begin
              r_frame_err <= 1'b1;
              r_wptr      <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (r_rx_sync) begin
              r_state <= ST_STORE;
            end else begin
              r_frame_err <= 1'b1;
              r_wptr      <= '0;
              r_state     <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_STORE: begin
          r_state <= ST_IDLE;
          if (r_complete) begin
            r_overflow <= 1'b1;
          end else if (w_is_null) begin
            r_length   <= r_wptr;
            r_wptr     <= '0;
            r_complete <= 1'b1;
          end else if (w_at_last) begin
            r_overflow <= 1'b1;
            r_length   <= PTR_LAST;
            r_wptr     <= '0;
            r_complete <= 1'b1;
          end else begin
            r_wptr <= r_wptr + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pov_string_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (RdAddr),
    .o_rdata (RdData)
  );

  assign Complete   = r_complete;
  assign Length     = r_length;
  assign FrameError = r_frame_err;
  assign Overflow   = r_overflow;

endmodule

// File: tb/tb_pov_string_receiver.sv
// tb/tb_pov_string_receiver.sv - self-checking bench for pov_string_receiver
module tb_pov_string_receiver;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk    = 1'b0;
  logic          Reset  = 1'b0;
  logic          RxD    = 1'b1;
  logic          Ack    = 1'b0;
  logic [AW-1:0] RdAddr = '0;
  logic [7:0]    RdData;
  logic          Complete;
  logic [AW-1:0] Length;
  logic          FrameError;
  logic          Overflow;

  always #5 clk = ~clk;

  pov_string_receiver #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH),
    .AW           (AW)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .RxD        (RxD),
    .Ack        (Ack),
    .RdAddr     (RdAddr),
    .RdData     (RdData),
    .Complete   (Complete),
    .Length     (Length),
    .FrameError (FrameError),
    .Overflow   (Overflow)
  );

  int tests  = 0;
  int fails  = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  // Pulse counters sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (FrameError === 1'b1) fe_cnt++;
    if (Overflow === 1'b1) ov_cnt++;
  end

  typedef struct {
    logic [7:0]    data;
    logic          stop;
    logic          ack_after;
    int            fe;
    int            ov;
    logic          cmp;
    logic [AW-1:0] len;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      RxD = d[b];
      repeat (CPB) @(negedge clk);
    end
    RxD = stop;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    chk("ack_clears_complete", Complete, 0);
  endtask

  task automatic rd(input int addr, input logic [7:0] exp);
    RdAddr = AW'(addr);
    #1;
    chk($sformatf("buffer[%0d]", addr), RdData, exp);
  endtask

  task automatic run_vec(input int i);
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(vecs[i].data, vecs[i].stop);
    chk($sformatf("v%0d_frame_err_pulses", i), fe_cnt - fe0, vecs[i].fe);
    chk($sformatf("v%0d_overflow_pulses", i), ov_cnt - ov0, vecs[i].ov);
    chk($sformatf("v%0d_complete", i), Complete, vecs[i].cmp);
    chk($sformatf("v%0d_length", i), Length, vecs[i].len);
    if (vecs[i].ack_after) do_ack();
  endtask

  initial begin
    int fe0;
    int ov0;

    //            data   stop  ack   fe ov cmp   len
    vecs[0]  = '{8'h48, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[1]  = '{8'h49, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[2]  = '{8'h00, 1'b1, 1'b1, 0, 0, 1'b1, 3'd2};
    vecs[3]  = '{8'h41, 1'b0, 1'b0, 1, 0, 1'b0, 3'd2};
    vecs[4]  = '{8'h00, 1'b1, 1'b1, 0, 0, 1'b1, 3'd0};
    vecs[5]  = '{8'h31, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[6]  = '{8'h32, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[7]  = '{8'h33, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[8]  = '{8'h34, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[9]  = '{8'h35, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[10] = '{8'h36, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[11] = '{8'h37, 1'b1, 1'b0, 0, 0, 1'b0, 3'd0};
    vecs[12] = '{8'h38, 1'b1, 1'b0, 0, 1, 1'b1, 3'd7};
    vecs[13] = '{8'h39, 1'b1, 1'b1, 0, 1, 1'b1, 3'd7};

    // Reset held for three cycles.
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_complete", Complete, 0);
    chk("reset_frame_err", FrameError, 0);
    chk("reset_overflow", Overflow, 0);
    chk("reset_length", Length, 0);
    Reset = 1'b1;
    repeat (4) @(negedge clk);

    run_vec(0);

    // Start glitch: short low pulse must not start a frame or move the pointer.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_frame_err", fe_cnt - fe0, 0);
    chk("glitch_overflow", ov_cnt - ov0, 0);
    chk("glitch_complete", Complete, 0);
    rd(0, 8'h48);

    for (int i = 1; i <= 2; i++) run_vec(i);
    rd(0, 8'h48);
    rd(1, 8'h49);
    rd(2, 8'h00);

    for (int i = 3; i <= 13; i++) run_vec(i);
    for (int a = 0; a < 7; a++) rd(a, 8'(8'h31 + a));
    rd(7, 8'h00);

    // Reset in the middle of the data bits of 0x55.
    @(negedge clk);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_length", Length, 0);
    chk("midreset_complete", Complete, 0);
    Reset = 1'b1;
    repeat (5) @(negedge clk);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h00, 1'b1);
    chk("after_reset_complete", Complete, 1);
    chk("after_reset_length", Length, 0);
    chk("after_reset_frame_err", fe_cnt - fe0, 0);
    chk("after_reset_overflow", ov_cnt - ov0, 0);
    rd(0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
